// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Imported by the loader top, its checksum accumulator and its bus interface.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_CSUM,
      S_DONE,
      S_ERROR
   } loader_state_t;

   localparam logic [7:0] CSUM_GOOD = 8'h00;
   localparam int         INSTR_W   = 16;

   // Byte-stream side is open whenever a frame is still being parsed.
   function automatic logic state_accepts_bytes(input loader_state_t s);
      return (s != S_DONE) && (s != S_ERROR);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = the loader itself, slave = the stream source / memory side.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 16
);
   logic [7:0]         rx_data_i;
   logic               rx_valid_i;
   logic               rx_ready_o;
   logic               imem_we_o;
   logic [ADDR_W-1:0]  imem_addr_o;
   logic [INSTR_W-1:0] imem_wdata_o;

   modport master (
      input  rx_data_i, rx_valid_i,
      output rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
   );

   modport slave (
      output rx_data_i, rx_valid_i,
      input  rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o
   );
endinterface

// File: rtl/imem_loader_csum.sv
// 8-bit modular accumulator over every accepted frame byte.
// zero_o looks ahead: it reports whether the sum including byte_in would be CSUM_GOOD.
module loader_csum
   import imem_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       add_en,
   input  logic [7:0] byte_in,
   output logic [7:0] sum_o,
   output logic       zero_o
);

   logic [7:0] sum_q, sum_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      sum_d = sum_q;
      if (clear) begin
         sum_d = 8'h00;
      end else if (add_en) begin
         sum_d = sum_q + byte_in;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst) begin
         sum_q <= 8'h00;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o  = sum_q;
   assign zero_o = (8'(sum_q + byte_in) == CSUM_GOOD);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory programmer: parses LEN/N words/CSUM frames, writes words
// from address 0 and releases the processor only after a frame passes its checksum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = 16
)(
   input  logic                clk,
   input  logic                rst,
   imem_loader_if.master       bus,
   input  logic                reload_i,
   output logic                cpu_run_o,
   output logic                load_done_o,
   output logic                load_err_o,
   output logic [15:0]         words_loaded_o
);

   localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

   loader_state_t      state_q, state_d;
   logic [15:0]        len_q, len_d;
   logic [7:0]         hi_q, hi_d;
   logic [15:0]        words_q, words_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [INSTR_W-1:0] wdata_q, wdata_d;
   logic               run_q, run_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               rx_ready;
   logic               accept;
   logic               reload_go;
   logic               csum_zero;
   logic [7:0]         csum_sum_unused;

   assign rx_ready  = state_accepts_bytes(state_q);
   assign accept    = bus.rx_valid_i && rx_ready;
   assign reload_go = reload_i && !rx_ready;

   loader_csum u_csum (
      .clk     (clk),
      .rst     (rst),
      .clear   (reload_go),
      .add_en  (accept),
      .byte_in (bus.rx_data_i),
      .sum_o   (csum_sum_unused),
      .zero_o  (csum_zero)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      hi_d    = hi_q;
      words_d = words_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      if (reload_go) begin
         state_d = S_LEN_HI;
         len_d   = 16'h0000;
         words_d = 16'h0000;
      end else if (accept) begin
         unique case (state_q)
            S_LEN_HI: begin
               len_d   = {bus.rx_data_i, 8'h00};
               state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
               len_d = {len_q[15:8], bus.rx_data_i};
               if ({1'b0, len_d} > DEPTH_L) begin
                  state_d = S_ERROR;
               end else if (len_d == 16'h0000) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA_HI;
               end
            end
            S_DATA_HI: begin
               hi_d    = bus.rx_data_i;
               state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
               // Address is the pre-increment count, so a frame always writes 0..N-1.
               we_d    = 1'b1;
               addr_d  = ADDR_W'(words_q);
               wdata_d = {hi_q, bus.rx_data_i};
               words_d = words_q + 16'd1;
               state_d = (words_d == len_q) ? S_CSUM : S_DATA_HI;
            end
            S_CSUM: begin
               state_d = csum_zero ? S_DONE : S_ERROR;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end

      // Status flags are a registered decode of the next state, so they move on the transition edge.
      run_d  = (state_d == S_DONE);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_LEN_HI;
         len_q   <= 16'h0000;
         hi_q    <= 8'h00;
         words_q <= 16'h0000;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         hi_q    <= hi_d;
         words_q <= words_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         run_q   <= run_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.rx_ready_o   = rx_ready;
   assign bus.imem_we_o    = we_q;
   assign bus.imem_addr_o  = addr_q;
   assign bus.imem_wdata_o = wdata_q;
   assign cpu_run_o        = run_q;
   assign load_done_o      = done_q;
   assign load_err_o       = err_q;
   assign words_loaded_o   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level reference model predicts every output
// each cycle, and directed frames pin that model with literal expectations.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int DEPTH = 256;
   localparam int M_LOAD = 0, M_DONE = 1, M_ERR = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        reload_i = 1'b0;
   logic        cpu_run_o, load_done_o, load_err_o;
   logic [15:0] words_loaded_o;

   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(16)) bus ();

   imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .reload_i       (reload_i),
      .cpu_run_o      (cpu_run_o),
      .load_done_o    (load_done_o),
      .load_err_o     (load_err_o),
      .words_loaded_o (words_loaded_o)
   );

   int n_pass  = 0;
   int n_total = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   // Reference model: the frame so far is just the list of accepted bytes; everything
   // follows from its length, the declared word count and the byte sum.
   logic [7:0]  m_bytes[$];
   int          exp_status = M_LOAD;
   logic        exp_we = 1'b0;
   logic [15:0] exp_addr = 16'h0, exp_data = 16'h0;
   int          exp_words = 0;

   always @(posedge clk) begin
      int k, n, s;
      if (!rst) begin
         m_bytes.delete();
         exp_status = M_LOAD;
         exp_we = 1'b0;
         exp_words = 0;
      end else begin
         exp_we = 1'b0;
         if (exp_status != M_LOAD) begin
            if (reload_i) begin
               m_bytes.delete();
               exp_status = M_LOAD;
               exp_words = 0;
            end
         end else if (bus.rx_valid_i) begin
            m_bytes.push_back(bus.rx_data_i);
            k = m_bytes.size();
            n = (k >= 2) ? int'(m_bytes[0]) * 256 + int'(m_bytes[1]) : 0;
            if (k == 2 && n > DEPTH) begin
               exp_status = M_ERR;
            end else if (k > 2 && k <= 2 + 2 * n && (k % 2) == 0) begin
               exp_we = 1'b1;
               exp_addr = 16'((k - 4) / 2);
               exp_data = {m_bytes[k-2], m_bytes[k-1]};
               exp_words++;
            end else if (k >= 3 && k == 3 + 2 * n) begin
               s = 0;
               foreach (m_bytes[i]) s += int'(m_bytes[i]);
               exp_status = ((s % 256) == 0) ? M_DONE : M_ERR;
            end
         end
      end
   end

   logic [31:0] obs[$];

   always @(negedge clk) begin
      if (check_en) begin
         check("rx_ready", 32'(bus.rx_ready_o), 32'(exp_status == M_LOAD));
         check("imem_we", 32'(bus.imem_we_o), 32'(exp_we));
         if (exp_we) begin
            check("imem_addr", 32'(bus.imem_addr_o), 32'(exp_addr));
            check("imem_wdata", 32'(bus.imem_wdata_o), 32'(exp_data));
         end
         check("cpu_run", 32'(cpu_run_o), 32'(exp_status == M_DONE));
         check("load_done", 32'(load_done_o), 32'(exp_status == M_DONE));
         check("load_err", 32'(load_err_o), 32'(exp_status == M_ERR));
         check("words_loaded", 32'(words_loaded_o), 32'(exp_words));
         if (bus.imem_we_o === 1'b1) obs.push_back({bus.imem_addr_o, bus.imem_wdata_o});
      end
   end

   // Inputs change 2 time units after a rising edge; idle gaps may carry noise on reload_i.
   task automatic send_byte(input logic [7:0] b, input bit throttle);
      int waited = 0;
      if (throttle) begin
         repeat ($urandom_range(0, 2)) begin
            bus.rx_valid_i = 1'b0;
            bus.rx_data_i  = 8'($urandom);
            reload_i       = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
         end
         reload_i = 1'b0;
      end
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = b;
      while (bus.rx_ready_o !== 1'b1 && waited < 50) begin
         @(posedge clk); #2;
         waited++;
      end
      if (waited >= 50) begin
         check("rx_ready_timeout", 32'(bus.rx_ready_o), 32'd1);
      end else begin
         @(posedge clk); #2;
      end
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] f[$], input bit throttle);
      foreach (f[i]) send_byte(f[i], throttle);
   endtask

   // Appends the trailer byte that makes the whole frame sum to 0x00.
   task automatic seal(inout logic [7:0] f[$]);
      logic [7:0] s = 8'h00;
      foreach (f[i]) s = s + f[i];
      f.push_back(8'h00 - s);
   endtask

   task automatic do_reload();
      reload_i = 1'b1;
      @(posedge clk); #2;
      reload_i = 1'b0;
   endtask

   task automatic idle(input int cycles, input bit noise);
      repeat (cycles) begin
         bus.rx_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.rx_data_i  = 8'($urandom);
         @(posedge clk); #2;
      end
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic check_good_result(input string tag);
      check({tag, "_writes"}, 32'(obs.size()), 32'd2);
      if (obs.size() == 2) begin
         check({tag, "_w0"}, obs[0], 32'h0000_1234);
         check({tag, "_w1"}, obs[1], 32'h0001_ABCD);
      end
      check({tag, "_done"}, 32'(load_done_o), 32'd1);
      check({tag, "_run"}, 32'(cpu_run_o), 32'd1);
      check({tag, "_ready"}, 32'(bus.rx_ready_o), 32'd0);
   endtask

   initial begin
      logic [7:0] good[$];
      logic [7:0] f[$];
      int n;

      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = 8'h00;
      good = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      seal(good);

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_rx_ready", 32'(bus.rx_ready_o), 32'd1);
      check("reset_cpu_run", 32'(cpu_run_o), 32'd0);
      check("reset_imem_we", 32'(bus.imem_we_o), 32'd0);
      check("reset_words", 32'(words_loaded_o), 32'd0);
      check_en = 1'b1;
      rst = 1'b1;

      obs.delete();
      send_frame(good, 1'b0);
      idle(2, 1'b1);
      check_good_result("good");

      do_reload();
      check("reload_run_drop", 32'(cpu_run_o), 32'd0);
      check("reload_ready", 32'(bus.rx_ready_o), 32'd1);
      obs.delete();
      send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
      idle(1, 1'b0);
      check("zero_len_writes", 32'(obs.size()), 32'd0);
      check("zero_len_done", 32'(load_done_o), 32'd1);

      do_reload();
      obs.delete();
      send_frame('{8'h00, 8'h01, 8'h12, 8'h34, 8'h00}, 1'b0);
      idle(1, 1'b0);
      check("badcsum_writes", 32'(obs.size()), 32'd1);
      if (obs.size() == 1) check("badcsum_w0", obs[0], 32'h0000_1234);
      check("badcsum_err", 32'(load_err_o), 32'd1);
      check("badcsum_run", 32'(cpu_run_o), 32'd0);

      do_reload();
      obs.delete();
      send_frame('{8'h01, 8'h01}, 1'b0);
      check("oversize_err", 32'(load_err_o), 32'd1);
      check("oversize_ready", 32'(bus.rx_ready_o), 32'd0);
      idle(2, 1'b1);
      check("oversize_writes", 32'(obs.size()), 32'd0);

      // Largest accepted frame: exactly IMEM_DEPTH words, addresses 0..255.
      do_reload();
      obs.delete();
      f = '{8'h01, 8'h00};
      repeat (2 * DEPTH) f.push_back(8'($urandom));
      seal(f);
      send_frame(f, 1'b0);
      idle(1, 1'b0);
      check("full_writes", 32'(obs.size()), 32'(DEPTH));
      check("full_words", 32'(words_loaded_o), 32'h100);
      check("full_done", 32'(load_done_o), 32'd1);

      do_reload();
      obs.delete();
      send_frame(good, 1'b1);
      idle(2, 1'b0);
      check_good_result("throttled");

      do_reload();
      send_frame('{8'h00, 8'h02, 8'h12}, 1'b0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("midreset_words", 32'(words_loaded_o), 32'd0);
      check("midreset_ready", 32'(bus.rx_ready_o), 32'd1);
      check("midreset_run", 32'(cpu_run_o), 32'd0);
      rst = 1'b1;
      obs.delete();
      send_frame(good, 1'b0);
      idle(2, 1'b0);
      check_good_result("after_reset");

      for (int t = 0; t < 8; t++) begin
         do_reload();
         n = $urandom_range(0, 6);
         f = '{8'h00, 8'(n)};
         repeat (2 * n) f.push_back(8'($urandom));
         seal(f);
         if ($urandom_range(0, 2) == 0) f[f.size()-1] = f[f.size()-1] + 8'($urandom_range(1, 255));
         send_frame(f, 1'b1);
         idle(3, 1'b1);
      end

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not reach its summary");
      $fatal(1);
   end

endmodule
